// File: rtl/cdb_broadcast_queue_pkg.sv
// Shared CPU parameter package.
// Holds the default functional-unit count, result and tag widths, and the CDB
// entry width. The issue, ROB and register-file blocks build on the same
// constants. entry_width() gives the {tag,result} width for any overridden
// parameter set.
package cdb_broadcast_queue_pkg;

   localparam int CPU_NUM_FU     = 4;
   localparam int CPU_DATA_WIDTH = 32;
   localparam int CPU_TAG_WIDTH  = 7;
   localparam int CPU_CDB_DEPTH  = 8;
   localparam int CDB_W          = CPU_TAG_WIDTH + CPU_DATA_WIDTH;

   function automatic int entry_width(input int tag_w, input int data_w);
      return tag_w + data_w;
   endfunction

endpackage

// File: rtl/cdb_broadcast_queue_if.sv
// Bus bundle between the functional-unit array, the broadcast queue and the
// CDB consumers.
//   fu_done/fu_tag/fu_result : per-unit completion pulse and its payload
//   fu_queued                : per-unit one-cycle acknowledge
//   cdb_valid/cdb_tag/cdb_data, cdb_ready : CDB head with consumer handshake
//   count                    : queue occupancy
// The master modport is the queue's view. The slave modport is the view of
// the surrounding units.
interface cdb_broadcast_queue_if
   import cdb_broadcast_queue_pkg::*;
#(
   parameter int NUM_FU     = CPU_NUM_FU,
   parameter int DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int TAG_WIDTH  = CPU_TAG_WIDTH,
   parameter int DEPTH      = CPU_CDB_DEPTH
);

   logic [NUM_FU-1:0]            fu_done;
   logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
   logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
   logic [NUM_FU-1:0]            fu_queued;
   logic                         cdb_valid;
   logic [TAG_WIDTH-1:0]         cdb_tag;
   logic [DATA_WIDTH-1:0]        cdb_data;
   logic                         cdb_ready;
   logic [$clog2(DEPTH):0]       count;

   modport master (
      input  fu_done, fu_tag, fu_result, cdb_ready,
      output fu_queued, cdb_valid, cdb_tag, cdb_data, count
   );

   modport slave (
      output fu_done, fu_tag, fu_result, cdb_ready,
      input  fu_queued, cdb_valid, cdb_tag, cdb_data, count
   );

endinterface

// File: rtl/cdb_broadcast_queue_rr_arbiter.sv
// Round-robin arbiter. The dispatch stage reuses it.
//   clk, rst  : clock and synchronous active-high reset
//   req       : request vector
//   advance   : the grant was consumed this cycle. The pointer then moves
//               to the unit after the winner.
//   grant     : one-hot grant
//   grant_idx : encoded grant
//   any       : at least one request is present
// The search starts at rr_ptr. The pointer holds when no grant is consumed.
module rr_arbiter
   import cdb_broadcast_queue_pkg::*;
#(
   parameter int N  = CPU_NUM_FU,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] rr_ptr;

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant_idx  = IW'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance && any) begin
         rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/cdb_broadcast_queue.sv
// CDB broadcast queue.
// Captures one-cycle completion pulses from NUM_FU functional units. Grants
// them round-robin into a DEPTH-entry FIFO, one per cycle, and presents the
// FIFO head on the common data bus.
//   clk, rst : clock and synchronous active-high reset
//   bus      : cdb_broadcast_queue_if master modport. It carries the unit
//              done/tag/result inputs, the fu_queued acks, the CDB head with
//              cdb_ready, and the occupancy count.
// A unit's payload is sampled directly from its ports in the grant cycle.
// Units hold tag/result until one cycle after fu_queued, so no copy is kept.
module cdb_broadcast_queue
   import cdb_broadcast_queue_pkg::*;
#(
   parameter int NUM_FU     = CPU_NUM_FU,
   parameter int DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int TAG_WIDTH  = CPU_TAG_WIDTH,
   parameter int DEPTH      = CPU_CDB_DEPTH
) (
   input logic                clk,
   input logic                rst,
   cdb_broadcast_queue_if.master bus
);

   localparam int EW = entry_width(TAG_WIDTH, DATA_WIDTH);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] pending;
   logic [NUM_FU-1:0] req;
   logic [NUM_FU-1:0] grant;
   logic [GW-1:0]     grant_idx;
   logic              any;
   logic              push;
   logic              pop;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [NUM_FU-1:0] queued;
   logic [EW-1:0]     wr_entry;
   logic [EW-1:0]     head;
   logic [EW-1:0]     mem [DEPTH];

   // A done pulse can win arbitration in the cycle it arrives.
   assign req = pending | bus.fu_done;

   rr_arbiter #(.N(NUM_FU), .IW(GW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .advance   (push),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign pop  = (count != '0) & bus.cdb_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push = any & ((count < CW'(DEPTH)) | pop);

   always_comb begin
      wr_entry = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (GW'(i) == grant_idx) begin
            wr_entry = {bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH],
                        bus.fu_result[i*DATA_WIDTH +: DATA_WIDTH]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         queued  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         pending <= req & ~(push ? grant : '0);
         // The ack is registered so that cdb_ready has no combinational path
         // back to the units' dispatch logic.
         queued  <= push ? grant : '0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset. The pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head          = mem[rd_ptr];
   assign bus.cdb_valid = (count != '0);
   assign bus.cdb_tag   = head[EW-1 -: TAG_WIDTH];
   assign bus.cdb_data  = head[DATA_WIDTH-1:0];
   assign bus.fu_queued = queued;
   assign bus.count     = count;

endmodule
